// File: rtl/alu_seq.sv
// Handshaked sequential ALU: one op per valid/ready transfer, registered result and flags,
// shifts iterated SHIFT_STEP bits per cycle.
//   state   | meaning
//   IDLE    | no result held, ready for an op
//   SHIFT   | iterating a shift, input stalled
//   DONE    | result/flags valid, waiting for the consumer
module alu_seq #(
  parameter int WIDTH      = 16,
  parameter int SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       select,
  input  logic             arith,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             busy
);

  localparam int LW = $clog2(WIDTH);
  localparam int CW = LW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4, OP_SHL = 3'd5, OP_SHR = 3'd6, OP_CMP = 3'd7;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_out;
  logic             r_z, r_n, r_c, r_v;
  logic [WIDTH-1:0] r_sh_val;
  logic [CW-1:0]    r_sh_rem;
  logic             r_sh_left;
  logic             r_arith;

  logic             w_accept;
  logic [LW-1:0]    w_n;
  logic             w_shift_go;
  logic [WIDTH:0]   w_sum, w_diff;
  logic             w_gt;
  logic [WIDTH-1:0] w_res;
  logic             w_c, w_v;

  assign in_ready   = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign out_valid  = (r_state == S_DONE);
  assign busy       = (r_state == S_SHIFT);
  assign alu_out    = r_out;
  assign flag_z     = r_z;
  assign flag_n     = r_n;
  assign flag_c     = r_c;
  assign flag_v     = r_v;

  assign w_accept   = in_valid && in_ready;
  assign w_n        = in_b[LW-1:0];
  assign w_shift_go = ((select == OP_SHL) || (select == OP_SHR)) && (w_n != '0);
  assign w_sum      = {1'b0, in_a} + {1'b0, in_b};
  assign w_diff     = {1'b0, in_a} - {1'b0, in_b};
  assign w_gt       = arith ? ($signed(in_a) > $signed(in_b)) : (in_a > in_b);

  // Single-cycle result; shifts only land here when the amount is zero.
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (select)
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (w_sum[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_diff[WIDTH-1:0];
        w_c   = w_diff[WIDTH];
        w_v   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (w_diff[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_AND:         w_res = in_a & in_b;
      OP_OR:          w_res = in_a | in_b;
      OP_XOR:         w_res = in_a ^ in_b;
      OP_SHL, OP_SHR: w_res = in_a;
      OP_CMP:         w_res = (in_a == in_b) ? '0 : (w_gt ? WIDTH'(1) : WIDTH'(2));
      default:        w_res = '0;
    endcase
  end

  logic [CW-1:0]       w_step;
  logic [CW-1:0]       w_rem_next;
  logic [WIDTH:0]      w_l_ext;
  logic [WIDTH:0]      w_r_log;
  logic signed [WIDTH:0] w_r_ari;
  logic [WIDTH-1:0]    w_sh_next;
  logic                w_sh_c;

  assign w_step     = (r_sh_rem < CW'(SHIFT_STEP)) ? r_sh_rem : CW'(SHIFT_STEP);
  assign w_rem_next = r_sh_rem - w_step;
  // One guard bit beyond each end captures the last bit shifted out.
  assign w_l_ext    = {1'b0, r_sh_val} << w_step;
  assign w_r_log    = {r_sh_val, 1'b0} >> w_step;
  assign w_r_ari    = $signed({r_sh_val, 1'b0}) >>> w_step;

  always_comb begin
    w_sh_next = '0;
    w_sh_c    = 1'b0;
    if (r_sh_left) begin
      w_sh_next = w_l_ext[WIDTH-1:0];
      w_sh_c    = w_l_ext[WIDTH];
    end else if (r_arith) begin
      w_sh_next = w_r_ari[WIDTH:1];
      w_sh_c    = w_r_ari[0];
    end else begin
      w_sh_next = w_r_log[WIDTH:1];
      w_sh_c    = w_r_log[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_out     <= '0;
      r_z       <= 1'b0;
      r_n       <= 1'b0;
      r_c       <= 1'b0;
      r_v       <= 1'b0;
      r_sh_val  <= '0;
      r_sh_rem  <= '0;
      r_sh_left <= 1'b0;
      r_arith   <= 1'b0;
    end else if (r_state == S_SHIFT) begin
      r_sh_val <= w_sh_next;
      r_sh_rem <= w_rem_next;
      if (w_rem_next == '0) begin
        r_out   <= w_sh_next;
        r_z     <= (w_sh_next == '0);
        r_n     <= w_sh_next[WIDTH-1];
        r_c     <= w_sh_c;
        r_v     <= 1'b0;
        r_state <= S_DONE;
      end
    end else if (w_accept) begin
      if (w_shift_go) begin
        r_sh_val  <= in_a;
        r_sh_rem  <= {1'b0, w_n};
        r_sh_left <= (select == OP_SHL);
        r_arith   <= arith;
        r_state   <= S_SHIFT;
      end else begin
        r_out   <= w_res;
        r_z     <= (w_res == '0);
        r_n     <= w_res[WIDTH-1];
        r_c     <= w_c;
        r_v     <= w_v;
        r_state <= S_DONE;
      end
    end else if (out_ready || (r_state != S_DONE)) begin
      r_state <= S_IDLE;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed cases, backpressure, mid-shift reset and a random sweep
// checked against a behavioural per-op model.
module tb_alu_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   select = 3'd0;
  logic         arith = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] alu_out;
  logic         flag_z, flag_n, flag_c, flag_v, busy;

  typedef struct packed {
    logic [W-1:0] res;
    logic [3:0]   f;   // {z, n, c, v}
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  alu_seq #(.WIDTH(W), .SHIFT_STEP(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .select(select), .arith(arith), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .alu_out(alu_out),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] r, input logic [3:0] f);
    exp_t e;
    e.res = r;
    e.f   = f;
    return e;
  endfunction

  function automatic exp_t model(input logic [2:0] sel, input logic ar,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0]   t;
    logic [W-1:0] r;
    logic         c, v;
    int           n;
    r = '0; c = 1'b0; v = 1'b0;
    n = int'(b) % W;
    case (sel)
      3'd0: begin
        t = {1'b0, a} + {1'b0, b};
        r = t[W-1:0]; c = t[W];
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'd1: begin
        r = a - b; c = (a < b);
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin
        r = a << n;
        if (n != 0) c = a[W-n];
      end
      3'd6: begin
        r = a;
        for (int i = 0; i < n; i++) r = {(ar ? r[W-1] : 1'b0), r[W-1:1]};
        if (n != 0) c = a[n-1];
      end
      default: begin
        if (a == b) r = '0;
        else if (ar ? ($signed(a) > $signed(b)) : (a > b)) r = 16'd1;
        else r = 16'd2;
      end
    endcase
    return mk(r, {(r == '0), r[W-1], c, v});
  endfunction

  // Output side of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("spurious_out", out_valid, 1'b0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("alu_out", alu_out, e.res);
        chk("flags", {flag_z, flag_n, flag_c, flag_v}, e.f);
      end
    end
  end

  // Called just after a rising edge with the block idle; returns just after the edge leaving DONE.
  task automatic run_op(input string tag, input logic [2:0] sel, input logic ar,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input exp_t e, input int exp_lat);
    int k;
    int lat;
    select = sel; arith = ar; in_a = a; in_b = b; in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_accept"}, in_ready, 1'b1);
    q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a   = W'($urandom);
    in_b   = W'($urandom);
    select = 3'($urandom_range(7));
    arith  = 1'($urandom_range(1));
    @(negedge clk);
    lat = 1;
    while (!out_valid && lat < 100) begin
      chk({tag, "_busy"}, busy, 1'b1);
      chk({tag, "_in_ready"}, in_ready, 1'b0);
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int nsh;
    logic [2:0]   s;
    logic         ar;
    logic [W-1:0] a, b;

    #12;
    chk("rst_alu_out", alu_out, 16'h0000);
    chk("rst_flags", {flag_z, flag_n, flag_c, flag_v}, 4'b0000);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add_wrap", 3'd0, 1'b0, 16'hFFFF, 16'h0001, mk(16'h0000, 4'b1010), 1);
    run_op("sub_ovf",  3'd1, 1'b0, 16'h8000, 16'h0001, mk(16'h7FFF, 4'b0001), 1);
    run_op("sub_brw",  3'd1, 1'b0, 16'h0003, 16'h0005, mk(16'hFFFE, 4'b0110), 1);
    run_op("shl_3",    3'd5, 1'b0, 16'h0001, 16'h0013, mk(16'h0008, 4'b0000), 4);
    run_op("sra_4",    3'd6, 1'b1, 16'h8000, 16'h0004, mk(16'hF800, 4'b0100), 5);
    run_op("srl_4",    3'd6, 1'b0, 16'h8000, 16'h0004, mk(16'h0800, 4'b0000), 5);
    run_op("shr_n0",   3'd6, 1'b1, 16'h9234, 16'h0010, mk(16'h9234, 4'b0100), 1);
    run_op("shl_c",    3'd5, 1'b0, 16'hC000, 16'h0001, mk(16'h8000, 4'b0110), 2);
    run_op("cmp_u",    3'd7, 1'b0, 16'hFFFF, 16'h0001, mk(16'h0001, 4'b0000), 1);
    run_op("cmp_s",    3'd7, 1'b1, 16'hFFFF, 16'h0001, mk(16'h0002, 4'b0000), 1);
    run_op("cmp_eq",   3'd7, 1'b0, 16'h1234, 16'h1234, mk(16'h0000, 4'b1000), 1);

    // Backpressure, then transfer plus accept in the same cycle.
    out_ready = 1'b0;
    select = 3'd4; arith = 1'b0; in_a = 16'hAAAA; in_b = 16'h5555; in_valid = 1'b1;
    @(negedge clk);
    chk("bp_accept", in_ready, 1'b1);
    q.push_back(mk(16'hFFFF, 4'b0100));
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_alu_out", alu_out, 16'hFFFF);
      chk("bp_flags", {flag_z, flag_n, flag_c, flag_v}, 4'b0100);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    select = 3'd3; in_a = 16'h00F0; in_b = 16'h0F00; in_valid = 1'b1;
    @(negedge clk);
    chk("b2b_in_ready", in_ready, 1'b1);
    q.push_back(mk(16'h0FF0, 4'b0000));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_valid", out_valid, 1'b1);
    @(posedge clk); #1;

    // Reset partway through a 10-bit shift.
    select = 3'd5; arith = 1'b0; in_a = 16'h0001; in_b = 16'h000A; in_valid = 1'b1;
    @(negedge clk);
    chk("rst_mid_accept", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", out_valid, 1'b0);
    chk("rst_mid_alu_out", alu_out, 16'h0000);
    chk("rst_mid_in_ready", in_ready, 1'b1);
    chk("rst_mid_busy_clr", busy, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("rst_no_result", cnt, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 60; i++) begin
      s  = 3'($urandom_range(7));
      ar = 1'($urandom_range(1));
      a  = W'($urandom);
      b  = (i % 3 == 0) ? W'($urandom_range(17)) : W'($urandom);
      if (i % 7 == 0) b = a;
      nsh = int'(b[3:0]);
      run_op("rnd", s, ar, a, b, model(s, ar, a, b),
             (((s == 3'd5) || (s == 3'd6)) && (nsh != 0)) ? 1 + nsh : 1);
    end

    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
